// File: rtl/hello_nios2_qsys_div_cell_pkg.sv
// rtl/hello_nios2_qsys_div_cell_pkg.sv - shared FSM encodings and latency helper for the divide cell
package hello_nios2_qsys_div_cell_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_FIX  = 2'd2
    } div_state_t;

    // Cycles from the start edge to the done cycle, inclusive of both.
    function automatic int div_latency(input int data_w);
        return data_w + 2;
    endfunction

endpackage

// File: rtl/hello_nios2_qsys_div_step.sv
// rtl/hello_nios2_qsys_div_step.sv - one combinational restoring-division step
module hello_nios2_qsys_div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_in,
    input  logic [DATA_W-1:0] quot_in,
    input  logic [DATA_W-1:0] den,
    output logic [DATA_W-1:0] rem_out,
    output logic [DATA_W-1:0] quot_out
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] diff;

    // The top bit of the (DATA_W+1)-bit difference acts as the borrow.
    always_comb begin
        shifted  = {rem_in, quot_in[DATA_W-1]};
        diff     = shifted - {1'b0, den};
        quot_out = {quot_in[DATA_W-2:0], 1'b0};
        rem_out  = shifted[DATA_W-1:0];
        if (!diff[DATA_W]) begin
            rem_out     = diff[DATA_W-1:0];
            quot_out[0] = 1'b1;
        end
    end

endmodule

// File: rtl/hello_nios2_qsys_div_cell.sv
// rtl/hello_nios2_qsys_div_cell.sv - iterative radix-2 restoring divider for DIV/DIVU
module hello_nios2_qsys_div_cell
    import hello_nios2_qsys_div_cell_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              A_div_start,
    input  logic              A_div_signed,
    input  logic [DATA_W-1:0] A_div_src1,
    input  logic [DATA_W-1:0] A_div_src2,
    output logic              A_div_busy,
    output logic              A_div_done,
    output logic [DATA_W-1:0] A_div_quot,
    output logic [DATA_W-1:0] A_div_rem
);

    localparam int CW = $clog2(DATA_W) + 1;

    div_state_t        state;
    logic [CW-1:0]     count;
    logic [DATA_W-1:0] rem_acc;
    logic [DATA_W-1:0] quot_acc;
    logic [DATA_W-1:0] den;
    logic [DATA_W-1:0] raw_src1;
    logic              neg_q;
    logic              neg_r;
    logic              div0;
    logic [DATA_W-1:0] rem_next;
    logic [DATA_W-1:0] quot_next;
    logic              s1;
    logic              s2;

    assign s1 = A_div_signed & A_div_src1[DATA_W-1];
    assign s2 = A_div_signed & A_div_src2[DATA_W-1];

    hello_nios2_qsys_div_step #(.DATA_W(DATA_W)) u_step (
        .rem_in   (rem_acc),
        .quot_in  (quot_acc),
        .den      (den),
        .rem_out  (rem_next),
        .quot_out (quot_next)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            count      <= '0;
            rem_acc    <= '0;
            quot_acc   <= '0;
            den        <= '0;
            raw_src1   <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div0       <= 1'b0;
            A_div_busy <= 1'b0;
            A_div_done <= 1'b0;
            A_div_quot <= '0;
            A_div_rem  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    A_div_done <= 1'b0;
                    if (A_div_start) begin
                        // The magnitude of the most negative value still fits as unsigned.
                        quot_acc   <= s1 ? -A_div_src1 : A_div_src1;
                        den        <= s2 ? -A_div_src2 : A_div_src2;
                        neg_q      <= s1 ^ s2;
                        neg_r      <= s1;
                        div0       <= (A_div_src2 == '0);
                        raw_src1   <= A_div_src1;
                        rem_acc    <= '0;
                        count      <= '0;
                        A_div_busy <= 1'b1;
                        state      <= ST_ITER;
                    end
                end
                ST_ITER: begin
                    rem_acc  <= rem_next;
                    quot_acc <= quot_next;
                    count    <= count + CW'(1);
                    if (count == CW'(DATA_W - 1))
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (div0) begin
                        A_div_quot <= '1;
                        A_div_rem  <= raw_src1;
                    end else begin
                        A_div_quot <= neg_q ? -quot_acc : quot_acc;
                        A_div_rem  <= neg_r ? -rem_acc : rem_acc;
                    end
                    A_div_done <= 1'b1;
                    A_div_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hello_nios2_qsys_div_cell.sv
// tb/tb_hello_nios2_qsys_div_cell.sv - directed self-checking bench for the divide cell
module tb_hello_nios2_qsys_div_cell;
    import hello_nios2_qsys_div_cell_pkg::*;

    localparam int LAT = div_latency(32);

    logic        clk;
    logic        reset;
    logic        start;
    logic        sgn;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] rem;

    int checks;
    int errors;

    hello_nios2_qsys_div_cell #(.DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .A_div_start  (start),
        .A_div_signed (sgn),
        .A_div_src1   (src1),
        .A_div_src2   (src2),
        .A_div_busy   (busy),
        .A_div_done   (done),
        .A_div_quot   (quot),
        .A_div_rem    (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after the start-sampling edge; returns the cycle number of done.
    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc      = 1;
        busy_cnt = 0;
        while (!done && cyc < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input bit hold, output int cyc, output int busy_cnt);
        @(negedge clk);
        start = 1'b1; sgn = s; src1 = a; src2 = b;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        wait_done(cyc, busy_cnt);
    endtask

    task automatic op_check(input string tag, input logic s, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
        int cyc, bc;
        do_op(s, a, b, 1'b0, cyc, bc);
        check({tag, "_lat"}, 32'(cyc), 32'(LAT));
        check({tag, "_quot"}, quot, eq);
        check({tag, "_rem"}, rem, er);
    endtask

    initial begin
        int cyc, bc, ndone;
        checks = 0; errors = 0;
        reset = 1'b1; start = 1'b0; sgn = 1'b0; src1 = '0; src2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quot", quot, 32'd0);
        check("rst_rem", rem, 32'd0);
        reset = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, 1'b0, cyc, bc);
        check("divu100_lat", 32'(cyc), 32'd34);
        check("divu100_busy_cycles", 32'(bc), 32'd33);
        check("divu100_busy_at_done", {31'd0, busy}, 32'd0);
        check("divu100_quot", quot, 32'd14);
        check("divu100_rem", rem, 32'd2);
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("quot_held", quot, 32'd14);

        op_check("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        op_check("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        op_check("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        op_check("divu_ovf", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
        op_check("divu_by0", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234);
        op_check("div_by0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB);

        // Start pulsed mid-operation must be ignored.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; src1 = 32'd200; src2 = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; src1 = 32'd50; src2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("ignored_start_dones", 32'(ndone), 32'd1);
        check("ignored_start_quot", quot, 32'd22);
        check("ignored_start_rem", rem, 32'd2);

        // Start held through done launches the next op immediately.
        do_op(1'b0, 32'd100, 32'd7, 1'b1, cyc, bc);
        check("hold_first_lat", 32'(cyc), 32'd34);
        check("hold_first_quot", quot, 32'd14);
        src1 = 32'd1000; src2 = 32'd10;
        @(posedge clk); #1;
        start = 1'b0;
        check("hold_second_busy", {31'd0, busy}, 32'd1);
        wait_done(cyc, bc);
        check("hold_second_lat", 32'(cyc), 32'd34);
        check("hold_second_quot", quot, 32'd100);
        check("hold_second_rem", rem, 32'd0);

        // Reset partway through an operation aborts it.
        @(negedge clk);
        start = 1'b1; sgn = 1'b0; src1 = 32'd12345; src2 = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_quot", quot, 32'd0);
        check("abort_rem", rem, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("abort_no_done", 32'(ndone), 32'd0);

        op_check("divu_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
